alu_muldiv: RTL

//  Parametrised successor to the single-cycle MIPS ALU: registered logic/arith/shift ops plus iterative

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/alu_muldiv.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU / mul-div unit.
// Optional divider hardware is controlled by the MULDIV_DIV_EN macro in the
// files that import this package.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_NOR   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_LUI   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SLL   = 4'h7;
    localparam logic [3:0] OP_MULT  = 4'h8;
    localparam logic [3:0] OP_MULTU = 4'h9;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_DIVU  = 4'hB;
    localparam logic [3:0] OP_MFHI  = 4'hC;
    localparam logic [3:0] OP_MFLO  = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iteration core for unsigned shift-add multiply and restoring divide.
// Operates on magnitudes; sign correction is done by the caller.
// Divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_mcand,
    input  logic             step,
    output logic             done,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
`ifdef MULDIV_DIV_EN
    logic             div_reg;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
`endif

    // Last step of the WIDTH-step run.
    assign done = step && (cnt_reg == CNT_W'(WIDTH - 1));

    // One step: multiplier bits leave acc_lo from the bottom while the partial
    // product enters from the top; divide shifts the dividend into the remainder.
    always_comb begin
        addend  = acc_lo[0] ? mcand_reg : '0;
        mul_sum = {1'b0, acc_hi} + {1'b0, addend};
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_reg};
        if (div_reg) begin
            if (!div_diff[WIDTH]) begin
                hi_next = div_diff[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_shift[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Operand load on start, then one update per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            mcand_reg <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
`ifdef MULDIV_DIV_EN
            div_reg   <= 1'b0;
`endif
        end else if (start) begin
            cnt_reg   <= '0;
            mcand_reg <= load_mcand;
            acc_hi    <= '0;
            acc_lo    <= load_lo;
`ifdef MULDIV_DIV_EN
            div_reg   <= is_div;
`endif
        end else if (step) begin
            cnt_reg <= cnt_reg + 1'b1;
            acc_hi  <= hi_next;
            acc_lo  <= lo_next;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU with registered single-cycle ops and iterative MULT/MULTU
// (and DIV/DIVU when MULDIV_DIV_EN is defined) writing HI/LO.
// Without MULDIV_DIV_EN opcodes A/B decode as illegal and div_by_zero is 0.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               div_by_zero,
    output logic               illegal_op,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_e             state_reg, state_next;
    logic               accept, is_multi, is_signed, is_div_op, skip_run;
    logic               sc_illegal, iter_done, iter_step, neg_p_reg;
    logic [WIDTH-1:0]   mag_a, mag_b, sc_result, fix_hi, fix_lo, iter_hi, iter_lo;
    logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
    logic               div_reg, neg_r_reg, dz_reg, dz_out_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    assign is_div_op   = (op == OP_DIV) || (op == OP_DIVU);
    assign skip_run    = dz_reg;
    assign div_by_zero = dz_out_reg;
`else
    assign is_div_op   = 1'b0;
    assign skip_run    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    assign in_ready  = (state_reg == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign is_multi  = (op == OP_MULT) || (op == OP_MULTU) || is_div_op;
    assign is_signed = (op == OP_MULT) || (is_div_op && op == OP_DIV);
    assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign iter_step = (state_reg == ST_RUN) && !skip_run;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start      (accept && is_multi),
`ifdef MULDIV_DIV_EN
        .is_div     (is_div_op),
`endif
        .load_lo    (is_div_op ? mag_a : mag_b),
        .load_mcand (is_div_op ? mag_b : mag_a),
        .step       (iter_step),
        .done       (iter_done),
        .acc_hi     (iter_hi),
        .acc_lo     (iter_lo)
    );

    // Single-cycle datapath; anything not handled here is illegal.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (op)
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_NOR:  sc_result = ~(a | b);
            OP_ADD:  sc_result = a + b;
            OP_SUB:  sc_result = a - b;
            OP_LUI:  sc_result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SRL:  sc_result = b >> shamt;
            OP_SLL:  sc_result = b << shamt;
            OP_MFHI: sc_result = hi;
            OP_MFLO: sc_result = lo;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Sign correction of the unsigned core result into HI/LO values.
    always_comb begin
        prod = {iter_hi, iter_lo};
        if (neg_p_reg) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (div_reg) begin
            fix_lo = neg_p_reg ? -iter_lo : iter_lo;
            fix_hi = neg_r_reg ? -iter_hi : iter_hi;
            if (dz_reg) begin
                fix_lo = '1;
                fix_hi = a_raw_reg;
            end
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next state: divide-by-zero skips the iteration steps.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && is_multi) state_next = ST_RUN;
            ST_RUN:  if (skip_run || iter_done) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture sign/flag context of an accepted multi-cycle op.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_p_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_reg   <= 1'b0;
            neg_r_reg <= 1'b0;
            dz_reg    <= 1'b0;
            a_raw_reg <= '0;
`endif
        end else if (accept && is_multi) begin
            neg_p_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            div_reg   <= is_div_op;
            neg_r_reg <= is_signed && a[WIDTH-1];
            dz_reg    <= is_div_op && (b == '0);
            a_raw_reg <= a;
`endif
        end
    end

    // Registered outputs and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
            hi         <= '0;
            lo         <= '0;
`ifdef MULDIV_DIV_EN
            dz_out_reg <= 1'b0;
`endif
        end else begin
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
`ifdef MULDIV_DIV_EN
            dz_out_reg <= 1'b0;
`endif
            if (accept && !is_multi) begin
                out_valid  <= 1'b1;
                result     <= sc_result;
                zero       <= (sc_result == '0);
                illegal_op <= sc_illegal;
            end
            if (state_reg == ST_FIX) begin
                out_valid <= 1'b1;
                result    <= fix_lo;
                zero      <= (fix_lo == '0);
                hi        <= fix_hi;
                lo        <= fix_lo;
`ifdef MULDIV_DIV_EN
                dz_out_reg <= dz_reg;
`endif
            end
        end
    end

endmodule
